// File: rtl/wave_wr_pkg.sv
// rtl/wave_wr_pkg.sv - state encoding, edge codes and edge-compare helper for wave_ram_writer
package wave_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } wave_state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Crossing test on "below level" flags of the previous and current sample
  function automatic logic edge_hit(input logic edge_sel, input logic prev_below, input logic cur_below);
    if (edge_sel == EDGE_RISE) begin
      return prev_below && !cur_below;
    end
    return !prev_below && cur_below;
  endfunction

endpackage

// File: rtl/wave_trig_detect.sv
// rtl/wave_trig_detect.sv - previous-sample register and unsigned level-crossing compare
module wave_trig_detect
  import wave_wr_pkg::*;
#(
  parameter int c_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_smp_valid,
  input  logic [c_DATA_WIDTH-1:0] i_smp_data,
  input  logic [c_DATA_WIDTH-1:0] i_level,
  input  logic                    i_edge,
  output logic                    o_trig
);

  logic [c_DATA_WIDTH-1:0] r_prev;
  logic                    r_have_prev;
  logic                    w_prev_below;
  logic                    w_cur_below;

  // Remember the last accepted sample; a fresh capture starts with no history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else if (i_clear) begin
      r_have_prev <= 1'b0;
    end else if (i_smp_valid) begin
      r_prev      <= i_smp_data;
      r_have_prev <= 1'b1;
    end
  end

  assign w_prev_below = (r_prev < i_level);
  assign w_cur_below  = (i_smp_data < i_level);
  assign o_trig       = i_smp_valid && r_have_prev && edge_hit(i_edge, w_prev_below, w_cur_below);

endmodule

// File: rtl/wave_ram_writer.sv
// rtl/wave_ram_writer.sv - pre/post-trigger waveform capture into a circular RAM; WAVE_WR_FORCE_TRIG_EN adds force_trig
module wave_ram_writer
  import wave_wr_pkg::*;
#(
  parameter int c_ADDR_WIDTH = 10,
  parameter int c_DATA_WIDTH = 8,
  parameter int c_PRE_TRIG   = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic [c_DATA_WIDTH-1:0] smp_data,
  input  logic                    smp_valid,
  input  logic [c_DATA_WIDTH-1:0] trig_level,
  input  logic                    trig_edge,
  output logic [c_ADDR_WIDTH-1:0] ram_addr,
  output logic [c_DATA_WIDTH-1:0] ram_wr_data,
  output logic                    ram_wr_en,
  output logic                    busy,
  output logic                    done,
  output logic [c_ADDR_WIDTH-1:0] start_addr
`ifdef WAVE_WR_FORCE_TRIG_EN
  ,
  input  logic                    force_trig
`endif
);

  localparam logic [c_ADDR_WIDTH-1:0] c_ONE_A      = 1;
  localparam logic [c_ADDR_WIDTH:0]   c_ONE_P      = 1;
  localparam logic [c_ADDR_WIDTH-1:0] c_PRE_LAST   = c_ADDR_WIDTH'(c_PRE_TRIG - 1);
  localparam logic [c_ADDR_WIDTH:0]   c_POST_TOTAL = (c_ADDR_WIDTH + 1)'((1 << c_ADDR_WIDTH) - c_PRE_TRIG);

  wave_state_t             r_state;
  logic [c_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [c_ADDR_WIDTH-1:0] r_pre_cnt;
  logic [c_ADDR_WIDTH:0]   r_post_cnt;
  logic [c_DATA_WIDTH-1:0] r_level;
  logic                    r_edge;
  logic [c_ADDR_WIDTH-1:0] r_addr;
  logic [c_DATA_WIDTH-1:0] r_data;
  logic                    r_wr_en;
  logic                    r_busy;
  logic                    r_done;
  logic [c_ADDR_WIDTH-1:0] r_start_addr;

  logic w_arm_ok;
  logic w_post_full;
  logic w_sample_ok;
  logic w_level_trig;
  logic w_force;
  logic w_trig;

`ifdef WAVE_WR_FORCE_TRIG_EN
  assign w_force = force_trig;
`else
  assign w_force = 1'b0;
`endif

  // Arm is only honoured when no capture is running
  assign w_arm_ok    = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Once the last post sample is in, the capture stops taking samples while it closes out
  assign w_post_full = (r_post_cnt == c_POST_TOTAL);
  assign w_sample_ok = smp_valid && ((r_state == ST_PRE) || (r_state == ST_ARMED) ||
                                     ((r_state == ST_POST) && !w_post_full));
  assign w_trig      = smp_valid && (w_level_trig || w_force);

  wave_trig_detect #(
    .c_DATA_WIDTH(c_DATA_WIDTH)
  ) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_arm_ok),
    .i_smp_valid(w_sample_ok),
    .i_smp_data (smp_data),
    .i_level    (r_level),
    .i_edge     (r_edge),
    .o_trig     (w_level_trig)
  );

  // Capture FSM with counters, registered RAM write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_level      <= '0;
      r_edge       <= EDGE_RISE;
      r_addr       <= '0;
      r_data       <= '0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_start_addr <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_sample_ok) begin
        r_wr_en  <= 1'b1;
        r_addr   <= r_wr_ptr;
        r_data   <= smp_data;
        r_wr_ptr <= r_wr_ptr + c_ONE_A;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_arm_ok) begin
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_ptr   <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_level    <= trig_level;
            r_edge     <= trig_edge;
            r_state    <= (c_PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (smp_valid) begin
            r_pre_cnt <= r_pre_cnt + c_ONE_A;
            if (r_pre_cnt == c_PRE_LAST) begin
              r_state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (w_trig) begin
            r_post_cnt <= c_ONE_P;
            r_state    <= ST_POST;
          end
        end
        ST_POST: begin
          if (w_post_full) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_start_addr <= r_wr_ptr;
          end else if (smp_valid) begin
            r_post_cnt <= r_post_cnt + c_ONE_P;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr    = r_addr;
  assign ram_wr_data = r_data;
  assign ram_wr_en   = r_wr_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign start_addr  = r_start_addr;

endmodule
